sysid_boot_checker: RTL and testbench

- Avalon-MM read master that sits directly upstream of the system-ID slave; the system-ID slave is a two-word read-only block.
- After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp), then captures both words.
- It compares them against build-time expected values and reports pass/fail flags, so board logic (LEDs, boot gating) can detect a mismatched FPGA image without software.

---
 rtl/sysid_boot_pkg.sv | 20 ++
 rtl/sysid_rd_latency_pipe.sv | 37 +++
 rtl/sysid_boot_checker.sv | 218 +++++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_boot_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_boot_pkg;

    localparam int unsigned SYSID_TMO_W   = 16;
    localparam logic        SYSID_ADDR_ID = 1'b0;
    localparam logic        SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        RD_ID   = 3'd0,
        WAIT_ID = 3'd1,
        RD_TS   = 3'd2,
        WAIT_TS = 3'd3,
        DONE    = 3'd4
    } sysid_state_e;

    function automatic logic is_rd_state(input sysid_state_e s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

endpackage

// File: rtl/sysid_rd_latency_pipe.sv
// Delays the read-accept strobe by DEPTH cycles to mark the edge on which the
// slave's read data is captured. DEPTH 0 is a pass-through.
module sysid_rd_latency_pipe #(
    parameter int unsigned DEPTH = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic in_strobe,
    output logic out_strobe
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clock ^ reset;
        assign out_strobe       = in_strobe;
    end else begin : g_shift
        logic [DEPTH-1:0] pipe_q;
        logic [DEPTH-1:0] pipe_d;

        // Shift the accept strobe one stage per cycle.
        always_comb begin
            pipe_d = (pipe_q << 1'b1) | DEPTH'(in_strobe);
        end

        // Pipeline stages.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign out_strobe = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the system-ID words and flags image mismatches.
// Optional irq/irq_ack ports are built when SYSID_BOOT_CHECKER_IRQ_EN is defined.
module sysid_boot_checker
    import sysid_boot_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1425177068,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    ,
    output logic        irq,
    input  logic        irq_ack
`endif
);

    localparam logic [SYSID_TMO_W-1:0] TMO_LIMIT = SYSID_TMO_W'(TIMEOUT_CYCLES);

    sysid_state_e           state_q, state_d;
    logic [SYSID_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0]            cap_id_q, cap_id_d;
    logic [31:0]            cap_ts_q, cap_ts_d;
    logic                   avm_read_q, avm_read_d;
    logic                   avm_address_q, avm_address_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   id_ok_q, id_ok_d;
    logic                   ts_ok_q, ts_ok_d;
    logic                   timeout_q, timeout_d;
    logic                   accept_s;
    logic                   stall_s;
    logic                   cap_s;
    logic                   enter_done_s;

    // avm_read_q is only ever high in an RD state, so it also gates waitrequest.
    assign accept_s = avm_read_q & ~avm_waitrequest;
    assign stall_s  = avm_read_q & avm_waitrequest;

    sysid_rd_latency_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_lat_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_strobe (accept_s),
        .out_strobe(cap_s)
    );

    // Sequencer: next state, stall counter and capture registers.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        timeout_d = timeout_q;
        case (state_q)
            RD_ID, RD_TS: begin
                if (accept_s) begin
                    tmo_cnt_d = '0;
                    if (!cap_s) begin
                        state_d = (state_q == RD_ID) ? WAIT_ID : WAIT_TS;
                    end else if (state_q == RD_ID) begin
                        cap_id_d = avm_readdata;
                        state_d  = RD_TS;
                    end else begin
                        cap_ts_d = avm_readdata;
                        state_d  = DONE;
                    end
                end else if (stall_s) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_cnt_d == TMO_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_ID: begin
                if (cap_s) begin
                    cap_id_d = avm_readdata;
                    state_d  = RD_TS;
                end else begin
                    state_d = WAIT_ID;
                end
            end
            WAIT_TS: begin
                if (cap_s) begin
                    cap_ts_d = avm_readdata;
                    state_d  = DONE;
                end else begin
                    state_d = WAIT_TS;
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = RD_ID;
                    timeout_d = 1'b0;
                    tmo_cnt_d = '0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = RD_ID;
            end
        endcase
    end

    assign enter_done_s = (state_d == DONE) && (state_q != DONE);

    // Compare flags: evaluated on DONE entry, cleared by a restart.
    always_comb begin
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        if (enter_done_s) begin
            id_ok_d = ~timeout_d & (cap_id_d == EXPECTED_ID);
            ts_ok_d = ~timeout_d & (cap_ts_d == EXPECTED_TS);
        end else if (state_q == DONE && start) begin
            id_ok_d = 1'b0;
            ts_ok_d = 1'b0;
        end else begin
            id_ok_d = id_ok_q;
            ts_ok_d = ts_ok_q;
        end
    end

    // Bus and status outputs are registered from the next state.
    always_comb begin
        avm_read_d    = is_rd_state(state_d);
        avm_address_d = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d        = (state_d != DONE);
        done_d        = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RD_ID;
            tmo_cnt_q     <= '0;
            cap_id_q      <= 32'h0000_0000;
            cap_ts_q      <= 32'h0000_0000;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cap_id_q      <= cap_id_d;
            cap_ts_q      <= cap_ts_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    logic irq_q, irq_d;

    // Sticky failure interrupt; a new set beats a simultaneous ack.
    always_comb begin
        irq_d = irq_q;
        if (enter_done_s && (!id_ok_d || !ts_ok_d || timeout_d)) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: three instances (latency 0, 2, 3) each
// driven by a small system-ID slave model.
module tb_sysid_boot_checker;

    localparam logic [31:0] TS_GOOD = 32'd1425177068;
    localparam logic [31:0] GARB    = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  start;
    logic [2:0]  rd, addr, busy, done, idok, tsok, tmo, wreq;
    logic [31:0] rdata [3];
    logic [31:0] cid   [3];
    logic [31:0] cts   [3];
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    logic [2:0]  irq, irq_ack;
`endif

    int          stall_cfg [3];
    bit          stuck_ts  [3];
    int          stall_cnt [3];
    int          rem       [3];
    logic        cap_addr  [3];
    logic [31:0] w_id      [3];
    logic [31:0] w_ts      [3];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int   cyc;
        int   inst;
        logic e_rd, e_addr, e_busy, e_done, e_idok, e_tsok;
    } trace_t;
    trace_t tr [15];

    always #5 clock = ~clock;

    sysid_boot_checker #(.EXPECTED_ID(32'h0000_0000), .READ_LATENCY(0), .TIMEOUT_CYCLES(4)) dut0 (
        .clock(clock), .reset(reset), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .id_ok(idok[0]), .ts_ok(tsok[0]), .timeout(tmo[0]),
        .captured_id(cid[0]), .captured_ts(cts[0])
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        , .irq(irq[0]), .irq_ack(irq_ack[0])
`endif
    );

    sysid_boot_checker #(.EXPECTED_ID(32'h0000_0000), .READ_LATENCY(2)) dut1 (
        .clock(clock), .reset(reset), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .id_ok(idok[1]), .ts_ok(tsok[1]), .timeout(tmo[1]),
        .captured_id(cid[1]), .captured_ts(cts[1])
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        , .irq(irq[1]), .irq_ack(irq_ack[1])
`endif
    );

    sysid_boot_checker #(.EXPECTED_ID(32'hCAFE_0001), .READ_LATENCY(3)) dut2 (
        .clock(clock), .reset(reset), .start(start[2]),
        .avm_address(addr[2]), .avm_read(rd[2]), .avm_waitrequest(wreq[2]), .avm_readdata(rdata[2]),
        .busy(busy[2]), .done(done[2]), .id_ok(idok[2]), .ts_ok(tsok[2]), .timeout(tmo[2]),
        .captured_id(cid[2]), .captured_ts(cts[2])
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        , .irq(irq[2]), .irq_ack(irq_ack[2])
`endif
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    function automatic logic [31:0] word_of(input int i, input logic a);
        return a ? w_ts[i] : w_id[i];
    endfunction

    // Slave model: data valid only in the capture cycle, garbage otherwise.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                stall_cnt[i] = 0;
                rem[i]       = 0;
                cap_addr[i]  = 1'b0;
                wreq[i]      = 1'b0;
                rdata[i]     = GARB;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] > 0) rem[i]--;
                if (rd[i]) begin
                    if (wreq[i]) begin
                        stall_cnt[i]++;
                    end else begin
                        stall_cnt[i] = 0;
                        rem[i]       = lat_of(i);
                        cap_addr[i]  = addr[i];
                    end
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                wreq[i] = rd[i] && ((stuck_ts[i] && addr[i]) || (stall_cnt[i] < stall_cfg[i]));
                if (lat_of(i) == 0)
                    rdata[i] = rd[i] ? word_of(i, addr[i]) : GARB;
                else
                    rdata[i] = (rem[i] == 1) ? word_of(i, cap_addr[i]) : GARB;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] status_of(input int i);
        return {26'd0, rd[i], busy[i], done[i], idok[i], tsok[i], tmo[i]};
    endfunction

    function automatic logic [31:0] status_exp(input logic r, b, d, io, to, t);
        return {26'd0, r, b, d, io, to, t};
    endfunction

    task automatic run_trace(input string tag);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            for (int k = 0; k < 15; k++) begin
                if (tr[k].cyc == c) begin
                    chk($sformatf("%s_stat_c%0d_u%0d", tag, c, tr[k].inst), status_of(tr[k].inst),
                        status_exp(tr[k].e_rd, tr[k].e_busy, tr[k].e_done, tr[k].e_idok, tr[k].e_tsok, 1'b0));
                    if (tr[k].e_rd)
                        chk($sformatf("%s_addr_c%0d_u%0d", tag, c, tr[k].inst),
                            32'(addr[tr[k].inst]), 32'(tr[k].e_addr));
                end
            end
        end
        chk({tag, "_cts0"}, cts[0], TS_GOOD);
        chk({tag, "_cts1"}, cts[1], 32'h1234_5678);
        chk({tag, "_cid2"}, cid[2], 32'hCAFE_0001);
        chk({tag, "_cts2"}, cts[2], TS_GOOD);
    endtask

    initial begin
        //            cyc inst rd    addr  busy  done  idok  tsok
        tr[0]  = '{0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[1]  = '{1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[2]  = '{2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tr[3]  = '{3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tr[4]  = '{0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[5]  = '{1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[6]  = '{3, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[7]  = '{5, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[8]  = '{6, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tr[9]  = '{0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[10] = '{2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[11] = '{4, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[12] = '{7, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr[13] = '{8, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tr[14] = '{9, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        start = 3'b000;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        irq_ack = 3'b000;
`endif
        for (int i = 0; i < 3; i++) begin
            stall_cfg[i] = 0;
            stuck_ts[i]  = 1'b0;
        end
        w_id[0] = 32'h0000_0000; w_ts[0] = TS_GOOD;
        w_id[1] = 32'h0000_0000; w_ts[1] = 32'h1234_5678;
        w_id[2] = 32'hCAFE_0001; w_ts[2] = TS_GOOD;

        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_stat_u%0d", i), status_of(i), 32'd0);
            chk($sformatf("rst_cap_u%0d", i), cid[i] | cts[i], 32'd0);
        end
        reset = 1'b0;
        run_trace("boot");
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        chk("irq_boot_u1", 32'(irq[1]), 32'd1);
        chk("irq_boot_u0", 32'(irq[0]), 32'd0);
`endif

        // Reset during WAIT_TS of the latency-3 instance.
        start[2] = 1'b1;
        @(negedge clock);
        start[2] = 1'b0;
        chk("restart_r0_u2", status_of(2), status_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (5) @(negedge clock);
        chk("wait_ts_u2", status_of(2), status_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        #1;
        chk("midrst_stat_u2", status_of(2), 32'd0);
        chk("midrst_cap_u2", cid[2] | cts[2], 32'd0);
        chk("midrst_stat_u0", status_of(0), 32'd0);
        chk("midrst_cap_u0", cts[0], 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_trace("rerun");

        // Three stall cycles per read; start while busy must be ignored.
        stall_cfg[0] = 3;
        start[0] = 1'b1;
        for (int r = 0; r < 10; r++) begin
            @(negedge clock);
            start[0] = (r == 2);
            chk($sformatf("stall_r%0d", r), status_of(0),
                status_exp(r < 8, r < 8, r >= 8, r >= 8, r >= 8, 1'b0));
            if (r < 8) chk($sformatf("stall_addr_r%0d", r), 32'(addr[0]), 32'(r >= 4));
        end
        start[0] = 1'b0;

        // Word 1 stuck in waitrequest: abort after four stalled cycles.
        stall_cfg[0] = 0;
        stuck_ts[0]  = 1'b1;
        w_id[0]      = 32'h0000_0BAD;
        start[0]     = 1'b1;
        for (int r = 0; r < 7; r++) begin
            @(negedge clock);
            start[0] = 1'b0;
            chk($sformatf("tmo_r%0d", r), status_of(0),
                status_exp(r <= 4, r <= 4, r >= 5, 1'b0, 1'b0, r >= 5));
        end
        chk("tmo_cid", cid[0], 32'h0000_0BAD);
        chk("tmo_cts_kept", cts[0], TS_GOOD);
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        chk("irq_tmo_set", 32'(irq[0]), 32'd1);
        irq_ack[0] = 1'b1;
        @(negedge clock);
        irq_ack[0] = 1'b0;
        chk("irq_tmo_ack", 32'(irq[0]), 32'd0);
`endif

        // Re-check with an ID mismatch; timeout must clear on restart.
        stuck_ts[0] = 1'b0;
        start[0]    = 1'b1;
        for (int r = 0; r < 5; r++) begin
            @(negedge clock);
            start[0] = 1'b0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
            irq_ack[0] = (r == 1) || (r == 3);
            if (r == 2) chk("irq_set_wins", 32'(irq[0]), 32'd1);
            if (r == 4) chk("irq_ack_clr", 32'(irq[0]), 32'd0);
`endif
            chk($sformatf("idbad_r%0d", r), status_of(0),
                status_exp(r < 2, r < 2, r >= 2, 1'b0, r >= 2, 1'b0));
        end
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        irq_ack[0] = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
